// File: rtl/ha_bist_driver.sv
// ha_bist_driver: self-test engine that sweeps all four half-adder input vectors and checks sum/cout.
// Optional macro HA_BIST_STOP_ON_FAIL_EN ends a run at the first mismatching vector.
module ha_bist_driver #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [3:0]       err_vec,
  output logic             fail_pulse,
  output logic [1:0]       fail_idx
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      LAST_SWEEP  = 16'(PASSES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = 1;

  state_t           r_state;
  logic [7:0]       r_settle_cnt;
  logic [15:0]      r_sweep;
  logic [1:0]       r_vec_idx;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_err;
  logic [1:0]       r_fidx;

  logic w_exp_sum;
  logic w_exp_cout;
  logic w_mismatch;
  logic w_last_vec;
  logic w_finish;

  // Expected response comes from the registered stimulus; X/Z on the DUT counts as a mismatch.
  assign w_exp_sum  = r_a ^ r_b;
  assign w_exp_cout = r_a & r_b;
  assign w_mismatch = (dut_sum !== w_exp_sum) || (dut_cout !== w_exp_cout);
  assign w_last_vec = (r_vec_idx == 2'd3);

`ifdef HA_BIST_STOP_ON_FAIL_EN
  assign w_finish = w_mismatch || (w_last_vec && (r_sweep == LAST_SWEEP));
`else
  assign w_finish = w_last_vec && (r_sweep == LAST_SWEEP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_sweep      <= '0;
      r_vec_idx    <= '0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fidx       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt        <= '0;
            r_err        <= '0;
            r_fidx       <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_vec_idx    <= '0;
            r_sweep      <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 8'd0) r_state <= S_CHECK;
          else r_settle_cnt <= r_settle_cnt - 8'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err[r_vec_idx] <= 1'b1;
            r_fidx           <= r_vec_idx;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
          end
          if (w_finish) begin
            // Stimulus is left on the last applied vector.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_last_vec) r_sweep <= r_sweep + 16'd1;
            r_vec_idx      <= r_vec_idx + 2'd1;
            {r_a, r_b}     <= r_vec_idx + 2'd1;
            r_settle_cnt   <= SETTLE_LOAD;
            r_state        <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dut_a        = r_a;
  assign dut_b        = r_b;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_done && (r_cnt == '0);
  assign mismatch_cnt = r_cnt;
  assign err_vec      = r_err;
  assign fail_idx     = r_fidx;
  assign fail_pulse   = (r_state == S_CHECK) && w_mismatch;
endmodule
